// File: rtl/spi_frame_rx_pkg.sv
// spi_frame_rx_pkg: shared FSM states and frame layout for the SPI write-frame receiver
package spi_frame_rx_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam int FRAME_BITS = 16;
  localparam int RW_BIT = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
  localparam int DEF_MAX_ADDR = 4;
endpackage

// File: rtl/spi_frame_rx_sync.sv
// sync_edge_det: multi-flop input synchronizer with rise/fall detection, edges suppressed until real samples fill the pipe
module sync_edge_det #(
  parameter int STAGES = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic [STAGES:0] vld;
  logic prev;
  // shift the pin through the synchronizer; vld tracks when q and prev hold genuine pin samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{IDLE_LVL}};
      prev <= IDLE_LVL;
      vld <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
      vld <= {vld[STAGES-1:0], 1'b1};
    end
  end
  assign q = sync[STAGES-1];
  assign rise = vld[STAGES] & q & ~prev;
  assign fall = vld[STAGES] & ~q & prev;
endmodule

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: deserializes 16-bit SPI mode-0 write frames into a valid/ready register write; SPI_FRAME_RX_ERR_CNT_EN adds err_count
module spi_frame_rx
  import spi_frame_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int MAX_ADDR = DEF_MAX_ADDR
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_raw,
  input  logic mosi_raw,
  input  logic cs_n_raw,
  output logic wr_valid,
  input  logic wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic frame_err,
  output logic overflow,
`ifdef SPI_FRAME_RX_ERR_CNT_EN
  output logic [7:0] err_count,
`endif
  output logic busy
);
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);
  localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] OVER_CNT = 5'(FRAME_BITS + 1);
  state_t state, nstate;
  logic [FRAME_BITS-1:0] shreg;
  logic [4:0] cnt;
  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic cs_q, cs_rise, cs_fall;
  logic commit, len_ok, rw, addr_bad, good, load, err_set, ovf_set;
  logic [ADDR_W-1:0] addr_f;
  logic unused_ok;
  sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(sclk_raw), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(mosi_raw), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
  sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(cs_n_raw), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  assign unused_ok = ^{sclk_q, sclk_fall, mosi_rise, mosi_fall};
  assign addr_f = ADDR_W'(shreg[ADDR_MSB:ADDR_LSB]);
  assign busy = state == SHIFT;
  // next state and the commit-cycle decision on the captured frame
  always_comb begin
    nstate = state == IDLE ? (cs_fall ? SHIFT : IDLE) : state == SHIFT ? (cs_rise ? COMMIT : SHIFT) : IDLE;
    commit = state == COMMIT;
    len_ok = cnt == FULL_CNT;
    rw = shreg[RW_BIT];
    addr_bad = addr_f > MAX_A;
    good = commit & len_ok & rw & ~addr_bad;
    load = good & (~wr_valid | wr_ready);
    ovf_set = good & wr_valid & ~wr_ready;
    err_set = commit & (~len_ok | (rw & addr_bad));
  end
  // state, shifter, hold register and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      wr_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nstate;
      frame_err <= err_set;
      overflow <= ovf_set;
      if (state == IDLE && cs_fall) begin
        shreg <= '0;
        cnt <= '0;
      end else if (state == SHIFT && sclk_rise && !cs_q) begin
        shreg <= {shreg[FRAME_BITS-2:0], mosi_q};
        cnt <= cnt == OVER_CNT ? OVER_CNT : cnt + 5'd1;
      end
      if (load) begin
        wr_valid <= 1'b1;
        wr_addr <= addr_f;
        wr_data <= DATA_W'(shreg[DATA_MSB:DATA_LSB]);
      end else if (wr_valid && wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end
`ifdef SPI_FRAME_RX_ERR_CNT_EN
  // saturating tally of error and overflow pulses
  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else if ((frame_err || overflow) && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif
endmodule
